value_change_logger: RTL

VALUE_CHANGE_LOGGER -- requirements
Module: value_change_logger

---
 rtl/value_change_logger.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/value_change_logger.sv
// value_change_logger: timestamps every change of in_data into a first-word-fall-through event FIFO.
// Defining VALUE_CHANGE_LOGGER_DROP_CNT_EN adds a saturating drop_cnt output.
module value_change_logger #(
    parameter int DATA_W = 8,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    clr_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [TS_W-1:0]         out_ts,
    output logic [$clog2(DEPTH):0]  count,
`ifdef VALUE_CHANGE_LOGGER_DROP_CNT_EN
    output logic [7:0]              drop_cnt,
`endif
    output logic                    overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              armed_q, armed_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [TS_W-1:0]   mem_ts_q   [DEPTH];

    logic log_s, full_s, pop_s, push_s, drop_s;

    // Event detection and FIFO handshake decode; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        log_s  = en && (!armed_q || (in_data != prev_q));
        full_s = (count_q == FULL_C);
        pop_s  = (count_q != {CW{1'b0}}) && out_ready;
        push_s = log_s && (!full_s || pop_s);
        drop_s = log_s && full_s && !pop_s;
    end

    // Next-state for timestamp, sample history, pointers, occupancy and sticky overflow.
    always_comb begin
        ts_d       = ts_q;
        prev_d     = prev_q;
        armed_d    = armed_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (en) begin
            ts_d    = ts_q + TS_W'(1);
            prev_d  = in_data;
            armed_d = 1'b1;
        end else begin
            ts_d    = ts_q;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + CW'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= {TS_W{1'b0}};
            prev_q     <= {DATA_W{1'b0}};
            armed_q    <= 1'b0;
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            armed_q    <= armed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Event storage; contents are only meaningful below count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_data_q[wr_ptr_q] <= in_data;
            mem_ts_q[wr_ptr_q]   <= ts_q;
        end
    end

    assign out_valid = (count_q != {CW{1'b0}});
    assign out_data  = mem_data_q[rd_ptr_q];
    assign out_ts    = mem_ts_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

`ifdef VALUE_CHANGE_LOGGER_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter; a drop in the same cycle as clr_ovf still counts.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_s) begin
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else if (clr_ovf) begin
            drop_cnt_d = 8'd0;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
